internal_data_bus_reg: RTL
==========================

# internal_data_bus_reg

Registered, parametrised successor to the combinational internal data bus multiplexer in the 65C02 datapath. Selects one of `SOURCES` register/ALU outputs onto the internal bus by highest-index priority, registers the result on `CLK`, and implements 6502-style bus behaviour when nothing drives: precharge or hold-last. It also reports driver contention, with a sticky flag and a saturating counter, for debug. It sits between the register file/ALU outputs and all internal bus consumers.

## Interface
- `WIDTH`, 8: bus width in bits.
- `SOURCES`, 8: number of bus drivers, legal range 2..16.
- `HOLD_MODE`, 0: idle-bus behaviour. 0 loads `PRECHARGE` when no select is active; 1 holds the last `OUT`.
- `PRECHARGE`, {WIDTH{1'b1}}: idle/reset bus value.
- `CLK`  input  1  system clock, rising-edge.
- `RST`  input  1  reset, asynchronous, active-high.
- `EN`  input  1  clock enable (RDY stall). When low, all state holds.
- `SEL`  input  SOURCES  one-hot-intended driver selects. Bit i selects source i.
- `IN`  input  SOURCES*WIDTH  packed sources. Source i is `IN[i*WIDTH +: WIDTH]`.
- `OUT`  output  WIDTH  registered bus value.
- `VALID`  output  1  registered. 1 when `OUT` was loaded from a driven source.
- `SRC`  output  SW  registered index of the winning source, where SW = max(1, $clog2(SOURCES)).
- `CONTENTION`  output  1  sticky: two or more `SEL` bits seen active (present only with `BUS_CONTENTION_EN`).
- `CONT_COUNT`  output  8  saturating count of contention cycles (present only with `BUS_CONTENTION_EN`).
- `CLR_CONT`  input  1  synchronous clear of `CONTENTION` and `CONT_COUNT` (present only with `BUS_CONTENTION_EN`).

## Operation
- Priority: the highest set bit of `SEL` wins, so with bits 7 and 2 both set, source 7 drives. This matches the existing bus priority order.
- Driven cycle (`EN`=1, `SEL`!=0):
  - `OUT` <= winning source.
  - `SRC` <= its index.
  - `VALID` <= 1.
- Idle cycle (`EN`=1, `SEL`==0):
  - `VALID` <= 0.
  - `SRC` holds.
  - `OUT` <= `PRECHARGE` if `HOLD_MODE`=0; `OUT` holds if `HOLD_MODE`=1.
- Stall (`EN`=0): `OUT`, `VALID`, `SRC`, `CONTENTION` and `CONT_COUNT` all hold. `SEL` and `IN` are ignored.
- Contention (`EN`=1 and popcount(`SEL`) >= 2):
  - `CONTENTION` <= 1.
  - `CONT_COUNT` <= `CONT_COUNT`+1, saturating at 255.
  - `OUT` still follows the priority winner.
- `CLR_CONT`=1 clears `CONTENTION` and `CONT_COUNT` to 0 on that edge regardless of `EN`. Clear wins over a simultaneous contention event.
- Inputs never propagate combinationally to outputs.

## Timing
- Latency is 1 cycle: `SEL`/`IN` sampled at edge n appear on `OUT`/`VALID`/`SRC` after edge n.
- Throughput: one selection per enabled cycle, with no bubbles.
- Reset values: `OUT`=`PRECHARGE`, `VALID`=0, `SRC`=0, `CONTENTION`=0, `CONT_COUNT`=0. These are applied immediately on `RST` assertion, including mid-operation.
- First enabled edge after `RST` deasserts behaves normally; there is no warm-up cycle.
- `SOURCES` not a power of two: `SRC` only ever takes values 0..SOURCES-1.
- Saturation: at `CONT_COUNT`=255 a further contention event leaves 255 and `CONTENTION` stays 1.

## Configuration
- `BUS_CONTENTION_EN` defined:
  - Popcount detection, `CONTENTION`, `CONT_COUNT` and `CLR_CONT` are present.
- Undefined:
  - Those three ports and their logic are removed.
  - Multiple selects still resolve by priority, silently.
  - All other behaviour is identical.

## Test plan
- Reset/idle, with WIDTH=8, SOURCES=8, HOLD_MODE=0:
  - Assert `RST` mid-stream -> `OUT`=8'hFF, `VALID`=0 and `SRC`=0 immediately.
  - Then `SEL`=0 -> `OUT` stays 8'hFF.
- Single driver and latency: source 3 = 8'hA5, `SEL`=8'h08 at edge n -> after edge n `OUT`=8'hA5, `VALID`=1, `SRC`=3; the previous cycle's value is visible before edge n.
- Priority and contention:
  - `SEL`=8'h84, source 7 = 8'h3C, source 2 = 8'h11 -> `OUT`=8'h3C, `SRC`=7, `CONTENTION`=1, `CONT_COUNT`=1.
  - 300 further contention cycles -> `CONT_COUNT`=255.
  - `CLR_CONT` with `SEL`=8'h84 -> both outputs 0.
- Stall: `OUT`=8'h55, then `EN`=0 with `SEL`=8'h01 and source 0 = 8'h99 for 4 cycles -> `OUT`=8'h55 and `CONT_COUNT` unchanged throughout; `EN`=1 -> `OUT`=8'h99 one edge later.
- Hold mode, HOLD_MODE=1:
  - Load 8'h42, then `SEL`=0 -> `OUT`=8'h42, `VALID`=0, `SRC` unchanged.
  - With HOLD_MODE=0 the same stimulus -> `OUT`=8'hFF.
- Non-power-of-two, SOURCES=5, WIDTH=16: `SEL`=5'b10000, source 4 = 16'hBEEF -> `OUT`=16'hBEEF, `SRC`=4 (3-bit).

Source files
------------

// File: rtl/internal_data_bus_reg.sv
// internal_data_bus_reg: registered priority multiplexer for the internal data bus.
// Latency 1 cycle from SEL/IN to OUT/VALID/SRC; EN low (RDY stall) freezes all state.
// Optional macro BUS_CONTENTION_EN adds multi-driver detection (CONTENTION, CONT_COUNT, CLR_CONT).
module internal_data_bus_reg #(
  parameter int                 WIDTH     = 8,
  parameter int                 SOURCES   = 8,
  parameter int                 HOLD_MODE = 0,
  parameter logic [WIDTH-1:0]   PRECHARGE = {WIDTH{1'b1}},
  localparam int                SW        = (SOURCES > 2) ? $clog2(SOURCES) : 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       EN,
  input  logic [SOURCES-1:0]         SEL,
  input  logic [SOURCES*WIDTH-1:0]   IN,
  output logic [WIDTH-1:0]           OUT,
  output logic                       VALID,
  output logic [SW-1:0]              SRC
`ifdef BUS_CONTENTION_EN
  ,
  input  logic                       CLR_CONT,
  output logic                       CONTENTION,
  output logic [7:0]                 CONT_COUNT
`endif
);

  // Winner of the current cycle's selection (combinational, never reaches outputs directly).
  logic             any_sel;
  logic [SW-1:0]    win_idx;
  logic [WIDTH-1:0] win_dat;

  // Priority encode: scanning upward lets the highest set bit overwrite lower ones,
  // which matches the existing bus priority order. Indices stay within 0..SOURCES-1
  // even when SOURCES is not a power of two.
  always_comb begin
    any_sel = 1'b0;
    win_idx = '0;
    win_dat = '0;
    for (int i = 0; i < SOURCES; i++) begin
      if (SEL[i]) begin
        any_sel = 1'b1;
        win_idx = SW'(i);
        win_dat = IN[i*WIDTH +: WIDTH];
      end
    end
  end

  // Bus register: load winner when driven, precharge or hold when idle, freeze on stall.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUT   <= PRECHARGE;
      VALID <= 1'b0;
      SRC   <= '0;
    end else if (EN) begin
      if (any_sel) begin
        OUT   <= win_dat;
        SRC   <= win_idx;
        VALID <= 1'b1;
      end else begin
        VALID <= 1'b0;
        if (HOLD_MODE == 0) begin
          OUT <= PRECHARGE;
        end
      end
    end
  end

`ifdef BUS_CONTENTION_EN
  // Two or more selects active: clearing the lowest set bit leaves something behind.
  logic multi_sel;

  // Contention detect without a full popcount adder tree.
  always_comb begin
    multi_sel = (SEL & (SEL - SOURCES'(1))) != '0;
  end

  // Sticky flag and saturating counter; clear has priority and ignores EN.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      CONTENTION <= 1'b0;
      CONT_COUNT <= 8'd0;
    end else if (CLR_CONT) begin
      CONTENTION <= 1'b0;
      CONT_COUNT <= 8'd0;
    end else if (EN && multi_sel) begin
      CONTENTION <= 1'b1;
      if (CONT_COUNT != 8'hFF) begin
        CONT_COUNT <= CONT_COUNT + 8'd1;
      end
    end
  end
`endif

endmodule
